// File: rtl/parity_tx_pkg.sv
// Shared types and defaults for the parity serial transmitter.
package parity_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

    // Counter width that stays at least one bit for a modulus of 1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parity_gen_df.sv
// Combinational parity of a data word: XOR chain, inverted for odd parity.
module parity_gen_df #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              odd,
    output logic              parity
);

    logic acc;

    always_comb begin
        acc = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            acc = acc ^ data[i];
        end
        parity = odd ? ~acc : acc;
    end

endmodule

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start bit, data LSB-first, parity, stop bit.
module parity_serial_tx
    import parity_tx_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit ODD_PARITY   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [BIT_W-1:0]  bit_idx, bit_idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par, par_n, par_din;
    logic              tx_n, busy_n, done_n;
    logic              bit_end;

    parity_gen_df #(.DATA_W(DATA_W)) u_par (
        .data   (din),
        .odd    (ODD_PARITY),
        .parity (par_din)
    );

    assign din_ready = (state == IDLE) && !rst;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_n     = par;
        done_n    = 1'b0;
        tx_n      = 1'b1;
        bit_end   = (cnt == CNT_LAST);

        if (state != IDLE) begin
            cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (din_valid && din_ready) begin
                    shreg_n   = din;
                    par_n     = par_din;
                    state_n   = START;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end
            end
            START:  if (bit_end) state_n = DATA;
            DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_idx == BIT_LAST) state_n = PARITY;
                    else                     bit_idx_n = bit_idx + BIT_W'(1);
                end
            end
            PARITY: if (bit_end) state_n = STOP;
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so derive them from the state being entered.
        busy_n = (state_n != IDLE);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            par     <= par_n;
            tx      <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx: three configurations against a queue-based frame model.
module tb_parity_serial_tx;

    localparam int NDUT = 3;
    localparam int NB   = 11;

    typedef struct {
        logic [7:0] d;
        logic       par_odd;
        logic       par_even;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      din = 8'h00;
    logic            din_valid = 1'b0;
    logic [NDUT-1:0] tx, busy, done, rdy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(1'b1)) u_odd4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
        .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) u_even4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
        .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .ODD_PARITY(1'b0)) u_even1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[2]),
        .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    function automatic int cpb_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit odd_of(input int k);
        return k == 0;
    endfunction

    // Frame as transmitted, bit 0 first: start, data, parity, stop.
    function automatic logic [NB-1:0] frame_of(input logic [7:0] d, input bit odd);
        int   ones;
        logic p;
        ones = $countones(d);
        p    = odd ? (ones % 2 == 0) : (ones % 2 == 1);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Reference model: per-DUT queue of the tx level for every upcoming cycle.
    bit              mq [NDUT][$];
    logic [NB-1:0]   mf [NDUT][$];
    logic [NDUT-1:0] m_done = '0;
    logic [NB-1:0]   mfr;

    initial forever begin
        @(posedge clk or posedge rst);
        for (int k = 0; k < NDUT; k++) begin
            m_done[k] = 1'b0;
            if (rst) begin
                mq[k].delete();
                mf[k].delete();
            end else if (mq[k].size() > 0) begin
                void'(mq[k].pop_front());
                m_done[k] = (mq[k].size() == 0);
            end else if (din_valid) begin
                mfr = frame_of(din, odd_of(k));
                mf[k].push_back(mfr);
                for (int b = 0; b < NB; b++)
                    for (int c = 0; c < cpb_of(k); c++) mq[k].push_back(mfr[b]);
            end
        end
    end

    // Per-cycle comparison plus frame capture (mid-bit sampling of tx while busy).
    bit            cap [NDUT][$];
    logic [NB-1:0] last_frame [NDUT];
    int            last_len [NDUT];
    logic [NB-1:0] cfr;

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("tx", k, tx[k], (mq[k].size() > 0) ? mq[k][0] : 1'b1);
            chk("busy", k, busy[k], mq[k].size() > 0);
            chk("done", k, done[k], m_done[k]);
            chk("din_ready", k, rdy[k], !rst && (mq[k].size() == 0));
            if (rst) begin
                cap[k].delete();
            end else begin
                if (busy[k]) cap[k].push_back(tx[k]);
                if (done[k]) begin
                    cfr = '0;
                    for (int b = 0; b < NB; b++)
                        if (b * cpb_of(k) + cpb_of(k) / 2 < cap[k].size())
                            cfr[b] = cap[k][b * cpb_of(k) + cpb_of(k) / 2];
                    last_frame[k] = cfr;
                    last_len[k]   = cap[k].size();
                    chk("frame_len", k, cap[k].size(), NB * cpb_of(k));
                    chk("frame_expected", k, mf[k].size() > 0, 1);
                    if (mf[k].size() > 0) chk("frame_bits", k, cfr, mf[k].pop_front());
                    cap[k].delete();
                end
            end
        end
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk); #2;
            if (rdy[0]) begin ok = 1'b1; break; end
        end
        chk("ready_timeout", 0, ok, 1);
    endtask

    task automatic send(input logic [7:0] d);
        wait_ready();
        din = d; din_valid = 1'b1;
        @(posedge clk); #2;
        din_valid = 1'b0;
        din = 8'($urandom);
    endtask

    task automatic wait_done(input int k, output int cyc);
        cyc = 0;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            if (done[k]) begin cyc = n; break; end
        end
        chk("done_timeout", k, cyc != 0, 1);
    endtask

    vec_t tbl [6];
    int   cyc, nb, ni, nd, bad, npulse;
    bit   got, sb, sr, sd;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b0};
        tbl[1] = '{8'h07, 1'b0, 1'b1};
        tbl[2] = '{8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h3C, 1'b1, 1'b0};
        tbl[4] = '{8'h81, 1'b1, 1'b0};
        tbl[5] = '{8'h01, 1'b0, 1'b1};

        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_tx", k, tx[k], 1);
            chk("rst_busy", k, busy[k], 0);
            chk("rst_done", k, done[k], 0);
            chk("rst_ready", k, rdy[k], 0);
        end
        @(posedge clk); #2;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].d);
            wait_done(0, cyc);
            #1;
            chk("tbl_done_cycle", 0, cyc, 45);
            chk("tbl_busy_len", 0, last_len[0], 44);
            chk("tbl_odd_frame", 0, last_frame[0], {1'b1, tbl[i].par_odd, tbl[i].d, 1'b0});
            chk("tbl_even_frame", 1, last_frame[1], {1'b1, tbl[i].par_even, tbl[i].d, 1'b0});
            chk("tbl_cpb1_frame", 2, last_frame[2], {1'b1, tbl[i].par_even, tbl[i].d, 1'b0});
            chk("tbl_cpb1_len", 2, last_len[2], 11);
        end

        // Back-to-back: valid held, din swapped mid-frame, next byte taken in the done cycle.
        wait_ready();
        din = 8'h3C; din_valid = 1'b1;
        nb = 0; ni = 0; nd = 0; bad = 0; got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            sb = busy[0]; sr = rdy[0]; sd = done[0];
            if (c == 20) din = 8'hFF;
            if (sd && nd == 1) begin
                #1;
                chk("b2b_second_frame", 0, last_frame[0], {1'b1, 1'b1, 8'hFF, 1'b0});
                got = 1'b1;
                break;
            end
            if (sb) begin
                nb++;
                if (sr) bad++;
            end else if (nb > 0) begin
                ni++;
            end
            if (sd) begin
                nd = 1;
                chk("b2b_ready_in_done", 0, sr, 1);
                #1;
                chk("b2b_first_frame", 0, last_frame[0], {1'b1, 1'b1, 8'h3C, 1'b0});
                @(posedge clk); #2;
                din_valid = 1'b0;
            end
        end
        chk("b2b_finished", 0, got, 1);
        chk("b2b_busy_cycles", 0, nb, 88);
        chk("b2b_gap_cycles", 0, ni, 1);
        chk("b2b_ready_low_in_frame", 0, bad, 0);
        din_valid = 1'b0;

        // Reset in cycle 20 of a frame (data bit 3 of 8'h42 is low).
        send(8'h42);
        repeat (19) @(posedge clk);
        #2;
        chk("pre_rst_tx", 0, tx[0], 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", 0, tx[0], 1);
        chk("mid_rst_busy", 0, busy[0], 0);
        chk("mid_rst_done", 0, done[0], 0);
        chk("mid_rst_ready", 0, rdy[0], 0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 0, rdy[0], 1);
        npulse = 0;
        repeat (60) begin
            @(negedge clk);
            if (done[0]) npulse++;
        end
        chk("rst_no_done", 0, npulse, 0);
        send(8'h81);
        wait_done(0, cyc);
        #1;
        chk("post_rst_done_cycle", 0, cyc, 45);
        chk("post_rst_frame", 0, last_frame[0], {1'b1, 1'b1, 8'h81, 1'b0});

        // Random traffic: valid and data change every cycle regardless of readiness.
        for (int n = 0; n < 800; n++) begin
            @(posedge clk); #2;
            din       = 8'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
        end
        din_valid = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        for (int k = 0; k < NDUT; k++) begin
            chk("drain_frames", k, mf[k].size(), 0);
            chk("drain_idle", k, busy[k], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
- Serial frame transmitter with a parity bit. It is the sending end of the XOR/XNOR parity-check path the team already uses on the receive side.
- Accepts a parallel byte through a valid/ready handshake. Shifts out start bit, data LSB-first, parity bit and stop bit on a single line.
- Each bit is held for a fixed number of clock cycles.
- Sits between lab datapath logic and any serial parity-checking receiver.

Parameters:
- DATA_W, 8, data bits per frame (2..16).
- CLKS_PER_BIT, 4, clock cycles each bit is held on tx (>=1).
- ODD_PARITY, 1, 1 = odd parity (XNOR reduction of data), 0 = even parity (XOR reduction).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  DATA_W  byte to transmit; sampled only on handshake.
- din_valid  input  1  din holds a byte to send.
- din_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, tx=1, busy=0, done=0, din_ready=0 while rst is high. Bit counter and cycle counter clear. Shift register clears.
- FSM states are IDLE, START, DATA, PARITY, STOP. All outputs are registered except din_ready, which equals (state==IDLE && !rst).
- Handshake: the transfer occurs on the rising edge where din_valid && din_ready.
  - On that edge, din is latched into the shift register and the parity bit is computed from din and latched.
  - State goes to START and tx=0 from the next cycle.
  - din_valid while not ready is ignored; din need not be held after the transfer.
- Bit timing: each state holds its tx value for exactly CLKS_PER_BIT cycles, counted by a cycle counter that runs 0..CLKS_PER_BIT-1 and wraps.
- START: tx=0, one bit time, then DATA.
- DATA: tx = shift register bit 0, shifting right at each bit-time boundary. After DATA_W bit times, go to PARITY.
- PARITY: tx = latched parity bit, one bit time.
  - Odd mode: parity = ~^din (total count of ones including parity is odd).
  - Even mode: parity = ^din.
- STOP: tx=1, one bit time. On its last cycle the next state is IDLE and done is asserted for the first IDLE cycle.
- Frame length: from the handshake edge, tx is low after 1 cycle. The full frame occupies (DATA_W+3)*CLKS_PER_BIT cycles of busy=1.
- Back-to-back: din_ready is high in the done cycle. A transfer in that cycle produces a START bit immediately after it, with no extra idle bit time.
- Reset mid-frame: tx returns high asynchronously. The frame is discarded and done does not pulse. After rst falls, the block is ready the next cycle.
- CLKS_PER_BIT=1: one cycle per bit; no counter wrap corner cases are allowed to drop or duplicate a bit.

Decomposition:
- Shared package parity_tx_pkg holds:
  - state encoding typedef (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - default DATA_W and CLKS_PER_BIT constants.
- Sub-module parity_gen_df: combinational parity reduction over DATA_W bits, with an odd/even select, built as an XOR chain with a final XNOR/inversion. The top level instantiates it on din.
- The FSM, counters and shift register stay in parity_serial_tx.

Test Plan:
- ODD_PARITY=1, CLKS_PER_BIT=4, din=8'hA5 handshake at cycle 0
  - tx per bit time: 0, 1,0,1,0,0,1,0,1, parity 1, stop 1.
  - busy high 44 cycles; done pulses at cycle 45.
- ODD_PARITY=0, din=8'h07: data bits 1,1,1,0,0,0,0,0, parity 1.
- ODD_PARITY=1, din=8'h07: parity bit 0.
- ODD_PARITY=1, din=8'h00: parity bit 1.
- din_valid held high with din changed to 8'hFF mid-frame (sending 8'h3C)
  - Transmitted byte stays 8'h3C; din_ready=0 throughout the frame.
  - 8'hFF is accepted in the done cycle, and its START bit immediately follows the first frame's stop bit (88 busy cycles total, 1 gap cycle).
- rst asserted at cycle 20 of a frame: tx=1 in the same cycle, busy=0, no done pulse. After rst falls, a new byte 8'h81 transmits a correct full frame.
- CLKS_PER_BIT=1, din=8'h01, ODD_PARITY=0: tx sequence 0,1,0,0,0,0,0,0,0,1,1 over 11 cycles.
